// File: rtl/seq_mult_datapath.sv
// Register stage of a shift-add multiplier: multiplicand A, multiplier B and
// product P, driven by load/shift/add commands from the sequencing controller.
module seq_mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               en_a,
    input  logic               ld_shift_a,
    input  logic               en_b,
    input  logic               ld_shift_b,
    input  logic               en_p,
    input  logic               ld_add_p,
    output logic               zero,
    output logic               lsb_b,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] p_q;

    // Multiplicand is kept double width so it can be shifted into product alignment.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a_q <= '0;
        end else if (en_a) begin
            a_q <= {{WIDTH{1'b0}}, a_in};
        end else if (ld_shift_a) begin
            a_q <= {a_q[2*WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            b_q <= '0;
        end else if (en_b) begin
            b_q <= b_in;
        end else if (ld_shift_b) begin
            b_q <= {1'b0, b_q[WIDTH-1:1]};
        end
    end

    // The add sees A before this edge, so add and shift may share a cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            p_q <= '0;
        end else if (en_p) begin
            p_q <= '0;
        end else if (ld_add_p) begin
            p_q <= p_q + a_q;
        end
    end

    assign zero    = (b_q == '0);
    assign lsb_b   = b_q[0];
    assign product = p_q;

endmodule
